// File: rtl/accu_window_unit.sv
// accu_window_unit
//
// Multi-channel windowed accumulator. CH signed sample streams share one
// input strobe and one output handshake. Each accepted sample is added into
// a per-channel sum of width SUM_W = DIN_W + clog2(WIN). That width is wide
// enough that no overflow can occur.
//
//   mode = 0 (block):   sums WIN samples, emits the total, then restarts
//                       from zero. Windows never overlap.
//   mode = 1 (sliding): emits the running sum of the last WIN samples on
//                       every sample, once WIN samples have been seen.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sync_clr   synchronous clear. It wins over every other input that
//              cycle, and the concurrent sample is dropped.
//   mode       window mode. It is registered internally. A change clears
//              the window state and drops that cycle's sample.
//   in_valid   din carries one sample per channel (no input backpressure)
//   din        packed samples, channel k at [k*DIN_W +: DIN_W]
//   dout       packed sums,    channel k at [k*SUM_W +: SUM_W]
//   out_valid  dout holds an unconsumed result
//   out_ready  downstream accepts dout
//   overrun    sticky: a result was overwritten before it was consumed
//
// Output handshake: a result is consumed on a cycle with out_valid &&
// out_ready. While out_valid is high and out_ready is low, dout is held.
// A new result in that state replaces dout and sets overrun. A result that
// coincides with a take simply replaces the consumed one.

module accu_window_unit #(
    parameter int CH    = 1,
    parameter int DIN_W = 37,
    parameter int WIN   = 50,
    localparam int SUM_W = DIN_W + $clog2(WIN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [CH*DIN_W-1:0]   din,
    output logic [CH*SUM_W-1:0]   dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(WIN + 1);
    localparam int PTR_W = $clog2(WIN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(WIN);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WIN - 1);

    logic             mode_q;
    logic [CNT_W-1:0] cnt;        // block mode: samples in current window
    logic [CNT_W-1:0] fill;       // sliding mode: valid history entries
    logic [PTR_W-1:0] wptr;       // sliding mode: oldest entry / next write
    logic [SUM_W-1:0] acc [CH];   // block accumulator or sliding sum

    // History RAM. It is not reset, because fill masks any stale content.
    logic [DIN_W-1:0] mem [CH][WIN];

    logic             restart;
    logic             accept;
    logic             blk_last;
    logic             win_full;
    logic             produce;
    logic [SUM_W-1:0] acc_next [CH];
    logic [CH*SUM_W-1:0] result;

    assign restart  = sync_clr || (mode != mode_q);
    assign accept   = in_valid && !restart;
    assign blk_last = (cnt == CNT_LAST);
    assign win_full = (fill == FILL_FULL);
    // In sliding mode the first result comes on the sample that takes fill
    // from WIN-1 to WIN, and a result follows on every sample after that.
    assign produce  = accept && (mode_q ? (fill >= CNT_LAST) : blk_last);

    always_comb begin
        logic [DIN_W-1:0] smp;
        logic [DIN_W-1:0] old_raw;
        logic [SUM_W-1:0] smp_ext;
        logic [SUM_W-1:0] old_ext;
        logic [SUM_W-1:0] add_sum;
        logic [SUM_W-1:0] slide_sum;
        smp       = '0;
        old_raw   = '0;
        smp_ext   = '0;
        old_ext   = '0;
        add_sum   = '0;
        slide_sum = '0;
        result    = '0;
        for (int k = 0; k < CH; k++) begin
            acc_next[k] = '0;
        end
        for (int k = 0; k < CH; k++) begin
            smp     = din[k*DIN_W +: DIN_W];
            smp_ext = {{(SUM_W-DIN_W){smp[DIN_W-1]}}, smp};
            old_raw = mem[k][wptr];
            // Until the window has filled, the slot under wptr was never
            // written in this run, so it contributes nothing.
            old_ext = win_full ? {{(SUM_W-DIN_W){old_raw[DIN_W-1]}}, old_raw} : '0;
            add_sum   = acc[k] + smp_ext;
            slide_sum = acc[k] + smp_ext - old_ext;
            if (mode_q) begin
                acc_next[k]                  = slide_sum;
                result[k*SUM_W +: SUM_W]     = slide_sum;
            end else begin
                acc_next[k]                  = blk_last ? '0 : add_sum;
                result[k*SUM_W +: SUM_W]     = add_sum;
            end
        end
    end

    // Window state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            cnt    <= '0;
            fill   <= '0;
            wptr   <= '0;
            for (int k = 0; k < CH; k++) acc[k] <= '0;
        end else if (restart) begin
            mode_q <= mode;
            cnt    <= '0;
            fill   <= '0;
            wptr   <= '0;
            for (int k = 0; k < CH; k++) acc[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < CH; k++) acc[k] <= acc_next[k];
            if (mode_q) begin
                if (!win_full) fill <= fill + CNT_W'(1);
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
            end else begin
                cnt <= blk_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && mode_q) begin
            for (int k = 0; k < CH; k++) mem[k][wptr] <= din[k*DIN_W +: DIN_W];
        end
    end

    // Output register and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (produce) begin
            dout      <= result;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
